mem_stage: RTL and testbench

- Execute/memory boundary stage that consumes the ALU result, store data and destination info produced by execute.
- Holds one instruction in an EX/MEM register.
- For LD/ST, runs a req/ready handshake to data memory and stalls upstream until the access completes.
- Delivers registered writeback results; non-memory results pass through unchanged, one cycle later.

---
 rtl/mem_stage.sv | 127 ++++++++++++
 tb/tb_mem_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// EX/MEM pipeline stage: holds one instruction, runs the data-memory
// req/ready handshake for LD/ST and delivers registered writeback results.
module mem_stage #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_p1,
  input  logic [15:0] alu_output_data,
  input  logic [15:0] rt_p1,
  input  logic        ldst_valid_idix_p1,
  input  logic        store_idix_p1,
  input  logic [2:0]  dest_reg_idix_p1,
  input  logic        reg_write_valid_idix_p1,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [2:0]  wb_dest_reg,
  output logic [15:0] wb_data,
  output logic        mem_err
);

  localparam int CW = (MEM_TIMEOUT <= 2) ? 1 : $clog2(MEM_TIMEOUT);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t        state;
  logic          m_valid;
  logic          m_ldst;
  logic          m_store;
  logic          m_reg_write;
  logic [2:0]    m_dest;
  logic [15:0]   m_alu;
  logic [15:0]   m_rt;
  logic [CW-1:0] tmo_cnt;

  logic in_access;
  logic timeout_hit;
  logic aligned_ldst_in;

  assign in_access       = (state == ACCESS);
  assign timeout_hit     = in_access & (tmo_cnt == CW'(MEM_TIMEOUT - 1)) & ~dmem_ready;
  assign mem_stall       = in_access & ~dmem_ready & ~timeout_hit;
  assign aligned_ldst_in = ex_valid_p1 & ldst_valid_idix_p1 & ~alu_output_data[0];

  // Memory interface is driven straight from M while the access is open.
  assign dmem_req   = in_access;
  assign dmem_we    = in_access & m_store;
  assign dmem_addr  = in_access ? {m_alu[15:1], 1'b0} : 16'h0000;
  assign dmem_wdata = in_access ? m_rt : 16'h0000;

  // EX/MEM register, access FSM, timeout counter and writeback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      m_valid      <= 1'b0;
      m_ldst       <= 1'b0;
      m_store      <= 1'b0;
      m_reg_write  <= 1'b0;
      m_dest       <= 3'd0;
      m_alu        <= 16'h0000;
      m_rt         <= 16'h0000;
      tmo_cnt      <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_dest_reg  <= 3'd0;
      wb_data      <= 16'h0000;
      mem_err      <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      mem_err      <= 1'b0;

      if (!mem_stall) begin
        m_valid     <= ex_valid_p1;
        m_ldst      <= ex_valid_p1 & ldst_valid_idix_p1;
        m_store     <= store_idix_p1;
        m_reg_write <= reg_write_valid_idix_p1;
        m_dest      <= dest_reg_idix_p1;
        m_alu       <= alu_output_data;
        m_rt        <= rt_p1;
        state       <= aligned_ldst_in ? ACCESS : IDLE;
        tmo_cnt     <= '0;
      end else begin
        tmo_cnt     <= tmo_cnt + CW'(1);
      end

      case (state)
        ACCESS: begin
          if (dmem_ready) begin
            wb_valid     <= 1'b1;
            wb_dest_reg  <= m_dest;
            wb_reg_write <= m_store ? 1'b0 : m_reg_write;
            wb_data      <= m_store ? 16'h0000 : dmem_rdata;
          end else if (timeout_hit) begin
            mem_err <= 1'b1;
          end else begin
            mem_err <= 1'b0;
          end
        end
        IDLE: begin
          // A LD/ST sitting in M while IDLE can only be a misaligned one.
          if (m_valid && m_ldst) begin
            mem_err <= 1'b1;
          end else if (m_valid) begin
            wb_valid     <= 1'b1;
            wb_dest_reg  <= m_dest;
            wb_reg_write <= m_reg_write;
            wb_data      <= m_alu;
          end else begin
            mem_err <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (MEM_TIMEOUT=4).
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_p1;
  logic [15:0] alu_output_data;
  logic [15:0] rt_p1;
  logic        ldst_valid_idix_p1;
  logic        store_idix_p1;
  logic [2:0]  dest_reg_idix_p1;
  logic        reg_write_valid_idix_p1;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ready;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [2:0]  wb_dest_reg;
  logic [15:0] wb_data;
  logic        mem_err;

  int errors = 0;
  int checks = 0;

  mem_stage #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ex_valid_p1(ex_valid_p1),
    .alu_output_data(alu_output_data), .rt_p1(rt_p1),
    .ldst_valid_idix_p1(ldst_valid_idix_p1), .store_idix_p1(store_idix_p1),
    .dest_reg_idix_p1(dest_reg_idix_p1),
    .reg_write_valid_idix_p1(reg_write_valid_idix_p1),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_dest_reg(wb_dest_reg), .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] rt,
                       input logic ldst, input logic st, input logic [2:0] dest, input logic rw);
    ex_valid_p1 = v; alu_output_data = alu; rt_p1 = rt; ldst_valid_idix_p1 = ldst;
    store_idix_p1 = st; dest_reg_idix_p1 = dest; reg_write_valid_idix_p1 = rw;
  endtask

  task automatic bubble();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; bubble(); dmem_ready = 1'b0; dmem_rdata = 16'h0000;
    tick(); tick();
    checks++; if ({mem_stall, dmem_req, dmem_we, wb_valid, wb_reg_write, mem_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000000", {mem_stall, dmem_req, dmem_we, wb_valid, wb_reg_write, mem_err}); end
    checks++; if ({dmem_addr, dmem_wdata, wb_data, wb_dest_reg} !== 51'b0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {dmem_addr, dmem_wdata, wb_data, wb_dest_reg}); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    drive(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 3'd3, 1'b1);
    tick(); bubble();
    checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL alu_capture got stall=%b req=%b wbv=%b exp=0,0,0", mem_stall, dmem_req, wb_valid); end
    tick();
    checks++; if ({wb_valid, wb_reg_write, wb_dest_reg, wb_data} !== {1'b1, 1'b1, 3'd3, 16'h1234}) begin
      errors++; $display("FAIL alu_wb got v=%b rw=%b d=%0d data=%h exp 1,1,3,1234", wb_valid, wb_reg_write, wb_dest_reg, wb_data); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got=%b exp=0", mem_stall); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_wb_clear got=%b exp=0", wb_valid); end
  endtask

  task automatic test_load();
    drive(1'b1, 16'h0040, 16'h0000, 1'b1, 1'b0, 3'd5, 1'b1);
    tick(); bubble();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin dmem_ready = 1'b1; dmem_rdata = 16'hBEEF; end
      #1;
      checks++; if (dmem_req !== 1'b1 || dmem_addr !== 16'h0040 || dmem_we !== 1'b0) begin
        errors++; $display("FAIL ld_req[%0d] got req=%b addr=%h we=%b exp 1,0040,0", i, dmem_req, dmem_addr, dmem_we); end
      checks++; if (mem_stall !== (i < 2)) begin
        errors++; $display("FAIL ld_stall[%0d] got=%b exp=%b", i, mem_stall, (i < 2)); end
      tick();
    end
    dmem_ready = 1'b0;
    checks++; if ({wb_valid, wb_reg_write, wb_dest_reg, wb_data, mem_err} !== {1'b1, 1'b1, 3'd5, 16'hBEEF, 1'b0}) begin
      errors++; $display("FAIL ld_wb got v=%b rw=%b d=%0d data=%h err=%b exp 1,1,5,beef,0", wb_valid, wb_reg_write, wb_dest_reg, wb_data, mem_err); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL ld_req_drop got=%b exp=0", dmem_req); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 16'h0010, 16'h00AA, 1'b1, 1'b1, 3'd4, 1'b1);
    tick();
    drive(1'b1, 16'h5555, 16'h0000, 1'b0, 1'b0, 3'd2, 1'b1);
    dmem_ready = 1'b1; #1;
    checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall} !== {1'b1, 1'b1, 16'h0010, 16'h00AA, 1'b0}) begin
      errors++; $display("FAIL st_req got req=%b we=%b addr=%h wd=%h stall=%b exp 1,1,0010,00aa,0", dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall); end
    tick(); dmem_ready = 1'b0; bubble();
    checks++; if ({wb_valid, wb_reg_write, wb_data} !== {1'b1, 1'b0, 16'h0000}) begin
      errors++; $display("FAIL st_wb got v=%b rw=%b data=%h exp 1,0,0000", wb_valid, wb_reg_write, wb_data); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL st_req_drop got=%b exp=0", dmem_req); end
    tick();
    checks++; if ({wb_valid, wb_reg_write, wb_dest_reg, wb_data} !== {1'b1, 1'b1, 3'd2, 16'h5555}) begin
      errors++; $display("FAIL b2b_alu_wb got v=%b rw=%b d=%0d data=%h exp 1,1,2,5555", wb_valid, wb_reg_write, wb_dest_reg, wb_data); end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 16'h0041, 16'h0000, 1'b1, 1'b0, 3'd1, 1'b1);
    tick(); bubble();
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL mis_req got req=%b stall=%b exp 0,0", dmem_req, mem_stall); end
    tick();
    checks++; if (mem_err !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL mis_err got err=%b wbv=%b exp 1,0", mem_err, wb_valid); end
    tick();
    checks++; if (mem_err !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL mis_clear got err=%b wbv=%b exp 0,0", mem_err, wb_valid); end
  endtask

  task automatic test_timeout();
    drive(1'b1, 16'h0080, 16'h0000, 1'b1, 1'b0, 3'd6, 1'b1);
    tick();
    drive(1'b1, 16'h0777, 16'h0000, 1'b0, 1'b0, 3'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (dmem_req !== 1'b1 || mem_stall !== (i < 3) || mem_err !== 1'b0) begin
        errors++; $display("FAIL tmo_cyc[%0d] got req=%b stall=%b err=%b exp 1,%b,0", i, dmem_req, mem_stall, mem_err, (i < 3)); end
      tick();
    end
    bubble();
    checks++; if (mem_err !== 1'b1 || wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL tmo_err got err=%b wbv=%b req=%b exp 1,0,0", mem_err, wb_valid, dmem_req); end
    tick();
    checks++; if ({mem_err, wb_valid, wb_dest_reg, wb_data} !== {1'b0, 1'b1, 3'd1, 16'h0777}) begin
      errors++; $display("FAIL tmo_next got err=%b v=%b d=%0d data=%h exp 0,1,1,0777", mem_err, wb_valid, wb_dest_reg, wb_data); end
    // Ready arriving on the limit cycle is a normal completion.
    drive(1'b1, 16'h0082, 16'h0000, 1'b1, 1'b0, 3'd7, 1'b1);
    tick(); bubble();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin dmem_ready = 1'b1; dmem_rdata = 16'h1357; end
      tick();
    end
    dmem_ready = 1'b0;
    checks++; if ({mem_err, wb_valid, wb_dest_reg, wb_data} !== {1'b0, 1'b1, 3'd7, 16'h1357}) begin
      errors++; $display("FAIL tmo_edge got err=%b v=%b d=%0d data=%h exp 0,1,7,1357", mem_err, wb_valid, wb_dest_reg, wb_data); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 16'h00C0, 16'h0000, 1'b1, 1'b0, 3'd2, 1'b1);
    tick(); bubble(); tick();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rmid_req got=%b exp=1", dmem_req); end
    rst = 1'b1;
    tick();
    checks++; if ({dmem_req, mem_stall, wb_valid, mem_err, dmem_addr} !== 20'b0) begin
      errors++; $display("FAIL rmid_clear got req=%b stall=%b v=%b err=%b addr=%h exp 0", dmem_req, mem_stall, wb_valid, mem_err, dmem_addr); end
    rst = 1'b0;
    tick();
    checks++; if (wb_valid !== 1'b0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL rmid_nowb got v=%b err=%b exp 0,0", wb_valid, mem_err); end
    drive(1'b1, 16'h00C4, 16'h0000, 1'b1, 1'b0, 3'd3, 1'b1);
    tick(); bubble();
    dmem_ready = 1'b1; dmem_rdata = 16'h2468;
    tick(); dmem_ready = 1'b0;
    checks++; if ({wb_valid, wb_reg_write, wb_dest_reg, wb_data} !== {1'b1, 1'b1, 3'd3, 16'h2468}) begin
      errors++; $display("FAIL rmid_fresh got v=%b rw=%b d=%0d data=%h exp 1,1,3,2468", wb_valid, wb_reg_write, wb_dest_reg, wb_data); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
